// File: rtl/logcmp_issue_if.sv
// Dispatch-to-issue-queue handshake channel for the logic/compare unit.
// The master side (dispatch) offers packed micro-ops; the slave side (queue) accepts.
interface logcmp_issue_if #(
    parameter int unsigned RNBIT = 2
);
    localparam int unsigned InfoW = 4 + 3 * (5 + RNBIT) + 66;

    logic             dispat_logCmp_valid;
    logic             dispat_logCmp_ready;
    logic [InfoW-1:0] dispat_logCmp_info;

    modport master (
        output dispat_logCmp_valid,
        output dispat_logCmp_info,
        input  dispat_logCmp_ready
    );

    modport slave (
        input  dispat_logCmp_valid,
        input  dispat_logCmp_info,
        output dispat_logCmp_ready
    );
endinterface

// File: rtl/logcmp_issue.sv
// In-order issue queue for the logic/compare execute unit: waits on the writeback log,
// reads operands and presents one registered micro-op per cycle to execute.
module logcmp_issue #(
    parameter int unsigned DP    = 4,
    parameter int unsigned RNBIT = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    logcmp_issue_if.slave               dispat,
    input  logic [32*(2**RNBIT)-1:0]    wbLog_qout,
    output logic [5+RNBIT-1:0]          regFile_rs1_addr,
    output logic [5+RNBIT-1:0]          regFile_rs2_addr,
    input  logic [63:0]                 regFile_rs1_data,
    input  logic [63:0]                 regFile_rs2_data,
    output logic                        logCmp_execute_vaild,
    output logic [4+(5+RNBIT)+129-1:0]  logCmp_execute_info
);
    localparam int unsigned PW   = 5 + RNBIT;
    localparam int unsigned OutW = 4 + PW + 129;
    localparam int unsigned AW   = $clog2(DP);
    localparam int unsigned PtrW = AW + 1;

    typedef struct packed {
        logic [3:0]    fun;
        logic [PW-1:0] rd0;
        logic [PW-1:0] rs1;
        logic [PW-1:0] rs2;
        logic [63:0]   imm;
        logic          is_imm;
        logic          is_usi;
    } entry_t;

    entry_t          mem_q [DP];
    entry_t          mem_d [DP];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            vaild_q, vaild_d;
    logic [OutW-1:0] info_q, info_d;

    entry_t          head;
    logic            empty, full, enq, issue;
    logic            rs1_zero, rs2_zero, rs1_rdy, rs2_rdy;
    logic [63:0]     op1, op2;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        // Same slot index with opposite wrap bits means the writer lapped the reader.
        full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        head  = mem_q[rd_ptr_q[AW-1:0]];

        rs1_zero = (head.rs1[PW-1:RNBIT] == '0);
        rs2_zero = (head.rs2[PW-1:RNBIT] == '0);
        rs1_rdy  = rs1_zero || wbLog_qout[head.rs1];
        rs2_rdy  = head.is_imm || rs2_zero || wbLog_qout[head.rs2];

        dispat.dispat_logCmp_ready = !full;
        enq   = dispat.dispat_logCmp_valid && !full && !flush;
        issue = !empty && rs1_rdy && rs2_rdy && !flush;

        regFile_rs1_addr = empty ? '0 : head.rs1;
        regFile_rs2_addr = empty ? '0 : head.rs2;

        op1 = rs1_zero ? 64'd0 : regFile_rs1_data;
        op2 = head.is_imm ? head.imm : (rs2_zero ? 64'd0 : regFile_rs2_data);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vaild_d  = 1'b0;
        info_d   = info_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q[AW-1:0]] = entry_t'(dispat.dispat_logCmp_info);
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                vaild_d  = 1'b1;
                info_d   = {head.fun, head.rd0, op1, op2, head.is_usi};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vaild_q  <= 1'b0;
            info_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vaild_q  <= vaild_d;
            info_q   <= info_d;
        end
    end

    // Entry payloads need no reset; the pointers alone define validity.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign logCmp_execute_vaild = vaild_q;
    assign logCmp_execute_info  = info_q;
endmodule

// File: tb/tb_logcmp_issue.sv
// Directed self-checking bench for logcmp_issue (DP=4, RNBIT=2).
module tb_logcmp_issue;
    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] wb = '0;
    logic [6:0]   rs1_addr, rs2_addr;
    logic [63:0]  rs1_data, rs2_data;
    logic         vaild;
    logic [139:0] info;
    logic [63:0]  rf [128];
    int           n_checks = 0;
    int           n_fail = 0;

    logcmp_issue_if #(.RNBIT(2)) dispat_if ();

    logcmp_issue #(.DP(4), .RNBIT(2)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .flush                (flush),
        .dispat               (dispat_if),
        .wbLog_qout           (wb),
        .regFile_rs1_addr     (rs1_addr),
        .regFile_rs2_addr     (rs2_addr),
        .regFile_rs1_data     (rs1_data),
        .regFile_rs2_data     (rs2_data),
        .logCmp_execute_vaild (vaild),
        .logCmp_execute_info  (info)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        rs1_data = rf[rs1_addr];
        rs2_data = rf[rs2_addr];
    end

    localparam logic [3:0] FAnd = 4'b0001, FOr = 4'b0010, FXor = 4'b0100, FSlt = 4'b1000;

    function automatic logic [90:0] mk_in(input logic [3:0] fun, input logic [6:0] rd0,
                                          input logic [6:0] rs1, input logic [6:0] rs2,
                                          input logic [63:0] imm, input logic is_imm,
                                          input logic is_usi);
        return {fun, rd0, rs1, rs2, imm, is_imm, is_usi};
    endfunction

    function automatic logic [139:0] mk_out(input logic [3:0] fun, input logic [6:0] rd0,
                                            input logic [63:0] op1, input logic [63:0] op2,
                                            input logic is_usi);
        return {fun, rd0, op1, op2, is_usi};
    endfunction

    task automatic chk(input string tag, input logic [139:0] got, input logic [139:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dispatch(input logic [90:0] op);
        dispat_if.dispat_logCmp_valid = 1'b1;
        dispat_if.dispat_logCmp_info  = op;
        tick();
        dispat_if.dispat_logCmp_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rf[i] = '0;
        rf[7'h0C] = 64'hFF00;
        rf[7'h10] = 64'h0F0F;
        rf[7'h28] = 64'h1234;
        rf[7'h2C] = 64'hABCD;
        dispat_if.dispat_logCmp_valid = 1'b0;
        dispat_if.dispat_logCmp_info  = '0;

        // 1: reset
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_vaild", 140'(vaild), 140'd0);
        chk("rst_info", info, 140'd0);
        chk("rst_ready", 140'(dispat_if.dispat_logCmp_ready), 140'd1);
        chk("rst_addr1", 140'(rs1_addr), 140'd0);
        chk("rst_addr2", 140'(rs2_addr), 140'd0);

        // 2: XOR with both sources already written
        wb[7'h0C] = 1'b1;
        wb[7'h10] = 1'b1;
        dispatch(mk_in(FXor, 7'h14, 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
        chk("xor_vaild_n1", 140'(vaild), 140'd0);
        chk("xor_addr1", 140'(rs1_addr), 140'h0C);
        chk("xor_addr2", 140'(rs2_addr), 140'h10);
        tick();
        chk("xor_vaild_n2", 140'(vaild), 140'd1);
        chk("xor_info", info, mk_out(FXor, 7'h14, 64'hFF00, 64'h0F0F, 1'b0));
        tick();
        chk("xor_vaild_n3", 140'(vaild), 140'd0);

        // 3: SLTIU, immediate masks the unwritten rs2, rs1 arch 0
        dispatch(mk_in(FSlt, 7'h15, 7'h01, 7'h24, '1, 1'b1, 1'b1));
        tick();
        chk("sltiu_vaild", 140'(vaild), 140'd1);
        chk("sltiu_info", info, mk_out(FSlt, 7'h15, 64'd0, '1, 1'b1));

        // 4: blocked head holds back a ready younger op
        dispatch(mk_in(FAnd, 7'h18, 7'h0C, 7'h28, 64'd0, 1'b0, 1'b0));
        dispatch(mk_in(FOr, 7'h19, 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            chk("block_vaild", 140'(vaild), 140'd0);
            tick();
        end
        wb[7'h28] = 1'b1;
        tick();
        chk("order_and", {139'd0, vaild} ^ info, 140'd1 ^ mk_out(FAnd, 7'h18, 64'hFF00,
            64'h1234, 1'b0));
        tick();
        chk("order_or_vaild", 140'(vaild), 140'd1);
        chk("order_or", info, mk_out(FOr, 7'h19, 64'hFF00, 64'h0F0F, 1'b0));
        tick();
        chk("order_idle", 140'(vaild), 140'd0);

        // 5: fill, refuse, drain; three rounds wrap the pointers
        for (int r = 0; r < 3; r++) begin
            wb[7'h2C] = 1'b0;
            dispatch(mk_in(FAnd, 7'(32 + 4 * r), 7'h0C, 7'h2C, 64'd0, 1'b0, 1'b0));
            for (int k = 1; k < 4; k++)
                dispatch(mk_in(FOr, 7'(32 + 4 * r + k), 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
            chk("full_ready", 140'(dispat_if.dispat_logCmp_ready), 140'd0);
            dispatch(mk_in(FXor, 7'h7F, 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
            chk("full_refuse_vaild", 140'(vaild), 140'd0);
            wb[7'h2C] = 1'b1;
            chk("full_no_reuse", 140'(dispat_if.dispat_logCmp_ready), 140'd0);
            tick();
            chk("drain0", info, mk_out(FAnd, 7'(32 + 4 * r), 64'hFF00, 64'hABCD, 1'b0));
            chk("drain_ready", 140'(dispat_if.dispat_logCmp_ready), 140'd1);
            for (int k = 1; k < 4; k++) begin
                tick();
                chk("drain_vaild", 140'(vaild), 140'd1);
                chk("drain_k", info, mk_out(FOr, 7'(32 + 4 * r + k), 64'hFF00, 64'h0F0F,
                    1'b0));
            end
            tick();
            chk("drain_done", 140'(vaild), 140'd0);
        end

        // 6: flush with dispatch valid and a ready head
        wb[7'h2C] = 1'b0;
        dispatch(mk_in(FAnd, 7'h30, 7'h0C, 7'h2C, 64'd0, 1'b0, 1'b0));
        dispatch(mk_in(FOr, 7'h31, 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
        dispatch(mk_in(FOr, 7'h32, 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
        wb[7'h2C] = 1'b1;
        flush = 1'b1;
        dispatch(mk_in(FXor, 7'h33, 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
        flush = 1'b0;
        chk("flush_vaild", 140'(vaild), 140'd0);
        chk("flush_empty_addr", 140'(rs1_addr), 140'd0);
        tick();
        chk("flush_no_issue", 140'(vaild), 140'd0);
        dispatch(mk_in(FXor, 7'h1A, 7'h0C, 7'h10, 64'd0, 1'b0, 1'b0));
        tick();
        chk("post_flush_vaild", 140'(vaild), 140'd1);
        chk("post_flush_info", info, mk_out(FXor, 7'h1A, 64'hFF00, 64'h0F0F, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
